// File: rtl/unified_mem_arb_pkg.sv
// unified_mem_pkg: shared state type, channel IDs and default parameters
// for the two-channel unified memory arbiter (unified_mem_arb).
package unified_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } umem_state_t;

  // Channel IDs; also the bit index of each channel in a one-hot grant.
  localparam logic CH_I = 1'b0;
  localparam logic CH_D = 1'b1;

  localparam int UMEM_WORD_W     = 16;
  localparam int UMEM_LINE_WORDS = 4;
  localparam int UMEM_ADDR_W     = 14;
  localparam int UMEM_LATENCY    = 4;

endpackage

// File: rtl/unified_mem_arb_if.sv
// unified_mem_arb_if: request/response bundle between the I-cache and D-cache
// miss handlers (master side) and the unified memory arbiter (slave side).
interface unified_mem_arb_if
  import unified_mem_pkg::*;
#(
  parameter int WORD_W     = UMEM_WORD_W,
  parameter int LINE_WORDS = UMEM_LINE_WORDS,
  parameter int ADDR_W     = UMEM_ADDR_W
) ();

  localparam int LW = WORD_W * LINE_WORDS;

  // Instruction channel (read-only)
  logic              i_re;
  logic [ADDR_W-1:0] i_addr;
  logic [LW-1:0]     i_rdata;
  logic              i_rdy;

  // Data channel (read/write with per-word mask)
  logic                  d_re;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [LW-1:0]         d_wdata;
  logic [LINE_WORDS-1:0] d_wmask;
  logic [LW-1:0]         d_rdata;
  logic                  d_rdy;

  modport master (
    output i_re, i_addr,
    input  i_rdata, i_rdy,
    output d_re, d_we, d_addr, d_wdata, d_wmask,
    input  d_rdata, d_rdy
  );

  modport slave (
    input  i_re, i_addr,
    output i_rdata, i_rdy,
    input  d_re, d_we, d_addr, d_wdata, d_wmask,
    output d_rdata, d_rdy
  );

endinterface

// File: rtl/unified_mem_arb_arbiter.sv
// umem_arbiter: picks one of the two channel requests and returns a one-hot
// grant indexed by channel ID. Define UMEM_RR_ARB_EN for round-robin
// arbitration; otherwise the data channel has fixed priority.
module umem_arbiter
  import unified_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic [1:0] w_grant;

`ifdef UMEM_RR_ARB_EN
  logic r_last;

  // Remember which channel won the most recent grant; data after reset so the
  // instruction channel takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= CH_D;
    end else if (i_advance && (|w_grant)) begin
      r_last <= w_grant[CH_D] ? CH_D : CH_I;
    end
  end

  // On a tie the channel that was not granted last wins.
  always_comb begin
    w_grant = i_req;
    if (i_req[CH_I] && i_req[CH_D]) begin
      w_grant = (r_last == CH_D) ? 2'b01 : 2'b10;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{clk, rst_n, i_advance};

  // Data always beats instruction; the instruction channel can starve.
  always_comb begin
    w_grant = 2'b00;
    if (i_req[CH_D]) begin
      w_grant = 2'b10;
    end else if (i_req[CH_I]) begin
      w_grant = 2'b01;
    end
  end
`endif

  assign o_grant = w_grant;

endmodule

// File: rtl/unified_mem_arb.sv
// unified_mem_arb: shared line-organised memory serving an instruction channel
// and a data channel through one serialising FSM with a fixed access latency.
// Build option: UMEM_RR_ARB_EN selects round-robin arbitration (see umem_arbiter).
module unified_mem_arb
  import unified_mem_pkg::*;
#(
  parameter int WORD_W     = UMEM_WORD_W,
  parameter int LINE_WORDS = UMEM_LINE_WORDS,
  parameter int ADDR_W     = UMEM_ADDR_W,
  parameter int LATENCY    = UMEM_LATENCY
) (
  input logic            clk,
  input logic            rst_n,
  unified_mem_arb_if.slave bus
);

  localparam int LW    = WORD_W * LINE_WORDS;
  localparam int CNT_W = $clog2(LATENCY);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_DONE   = DONE;

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_count;
  logic                  r_grant;
  logic [ADDR_W-1:0]     r_addr;
  logic [LW-1:0]         r_wdata;
  logic [LINE_WORDS-1:0] r_wmask;
  logic                  r_we;
  logic [LW-1:0]         r_iRdata;
  logic [LW-1:0]         r_dRdata;
  logic [LW-1:0]         r_mem [0:(2**ADDR_W)-1];

  logic [1:0] w_req;
  logic [1:0] w_grant;
  logic       w_accept;
  logic       w_commit;

  // A data request with both read and write high counts as one request.
  assign w_req[CH_I] = bus.i_re;
  assign w_req[CH_D] = bus.d_re | bus.d_we;

  assign w_accept = (r_state == ST_IDLE) && (|w_req);
  assign w_commit = (r_state == ST_ACCESS) && (r_count == CNT_W'(LATENCY - 2));

  umem_arbiter u_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (w_req),
    .i_advance (w_accept),
    .o_grant   (w_grant)
  );

  // Serialising FSM: accept one request in IDLE, wait out the latency in
  // ACCESS, then spend one DONE cycle signalling completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_grant <= CH_D;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_we    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_count <= '0;
          if (w_accept) begin
            r_state <= ST_ACCESS;
            r_grant <= w_grant[CH_D] ? CH_D : CH_I;
            r_addr  <= w_grant[CH_D] ? bus.d_addr : bus.i_addr;
            r_wdata <= bus.d_wdata;
            r_wmask <= bus.d_wmask;
            r_we    <= w_grant[CH_D] & bus.d_we;
          end
        end
        ST_ACCESS: begin
          if (w_commit) begin
            r_state <= ST_DONE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Array write: only words with their mask bit set change. The array is
  // never reset, and a write is dropped if reset is active at the commit edge.
  always_ff @(posedge clk) begin
    if (w_commit && r_we && rst_n) begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        if (r_wmask[k]) begin
          r_mem[r_addr][k*WORD_W +: WORD_W] <= r_wdata[k*WORD_W +: WORD_W];
        end
      end
    end
  end

  // Read-data registers: each holds its line until that channel's next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iRdata <= '0;
      r_dRdata <= '0;
    end else if (w_commit && !r_we) begin
      if (r_grant == CH_D) begin
        r_dRdata <= r_mem[r_addr];
      end else begin
        r_iRdata <= r_mem[r_addr];
      end
    end
  end

  assign bus.i_rdata = r_iRdata;
  assign bus.d_rdata = r_dRdata;
  assign bus.i_rdy   = !w_req[CH_I] || ((r_state == ST_DONE) && (r_grant == CH_I));
  assign bus.d_rdy   = !w_req[CH_D] || ((r_state == ST_DONE) && (r_grant == CH_D));

endmodule

// File: tb/tb_unified_mem_arb.sv
// tb_unified_mem_arb: directed and randomised checks of unified_mem_arb against
// a transaction-level model. Honours UMEM_RR_ARB_EN for the arbitration rule.
module tb_unified_mem_arb;
  import unified_mem_pkg::*;

  localparam int WORD_W     = 16;
  localparam int LINE_WORDS = 4;
  localparam int ADDR_W     = 14;
  localparam int LAT        = 4;
  localparam int LW         = WORD_W * LINE_WORDS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unified_mem_arb_if #(.WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) bus ();
  unified_mem_arb_if #(.WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) bus2 ();

  unified_mem_arb #(.WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  unified_mem_arb #(.WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W), .LATENCY(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Transaction-level model: one access in flight, completing LAT cycles after accept.
  logic [LW-1:0]         mMem [int];
  logic                  mBusy = 1'b0;
  int                    mDone = 0;
  logic                  mCh = 1'b0;
  logic [ADDR_W-1:0]     mAddr = '0;
  logic                  mWe = 1'b0;
  logic [LW-1:0]         mWdata = '0;
  logic [LINE_WORDS-1:0] mMask = '0;
  logic [LW-1:0]         mIRdata = '0;
  logic [LW-1:0]         mDRdata = '0;
  logic                  mIKnown = 1'b1;
  logic                  mDKnown = 1'b1;
  logic                  mLast = 1'b1;
  logic                  doneI = 1'b0;
  logic                  doneD = 1'b0;

  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Model step and per-cycle compare, away from the active clock edge.
  always @(negedge clk) begin
    logic reqI, reqD, pick;
    logic [LW-1:0] bm;
    cyc++;
    doneI = 1'b0;
    doneD = 1'b0;
    reqI = bus.i_re;
    reqD = bus.d_re | bus.d_we;
    if (!rst_n) begin
      mBusy = 1'b0;
      mIRdata = '0;
      mDRdata = '0;
      mIKnown = 1'b1;
      mDKnown = 1'b1;
      mLast = 1'b1;
    end else if (mBusy && cyc == mDone) begin
      if (mWe) begin
        bm = '0;
        for (int k = 0; k < LINE_WORDS; k++)
          if (mMask[k]) bm = bm | (LW'({WORD_W{1'b1}}) << (k * WORD_W));
        if (mMem.exists(int'(mAddr))) mMem[int'(mAddr)] = (mMem[int'(mAddr)] & ~bm) | (mWdata & bm);
        else if (&mMask) mMem[int'(mAddr)] = mWdata;
      end else if (mCh) begin
        mDKnown = mMem.exists(int'(mAddr));
        if (mDKnown) mDRdata = mMem[int'(mAddr)];
      end else begin
        mIKnown = mMem.exists(int'(mAddr));
        if (mIKnown) mIRdata = mMem[int'(mAddr)];
      end
      if (mCh) doneD = 1'b1;
      else doneI = 1'b1;
      mBusy = 1'b0;
    end else if (!mBusy && (reqI || reqD)) begin
      if (reqI && reqD) begin
`ifdef UMEM_RR_ARB_EN
        pick = !mLast;
`else
        pick = 1'b1;
`endif
      end else begin
        pick = reqD;
      end
      mLast = pick;
      mCh = pick;
      mAddr = pick ? bus.d_addr : bus.i_addr;
      mWe = pick && bus.d_we;
      mWdata = bus.d_wdata;
      mMask = bus.d_wmask;
      mBusy = 1'b1;
      mDone = cyc + LAT;
    end
    checkOutput("i_rdy", LW'(bus.i_rdy), LW'(!reqI || doneI));
    checkOutput("d_rdy", LW'(bus.d_rdy), LW'(!reqD || doneD));
    if (mIKnown) checkOutput("i_rdata", bus.i_rdata, mIRdata);
    if (mDKnown) checkOutput("d_rdata", bus.d_rdata, mDRdata);
  end

  task automatic applyStimulus(input logic ire, input logic [ADDR_W-1:0] iaddr, input logic dre,
                               input logic dwe, input logic [ADDR_W-1:0] daddr,
                               input logic [LW-1:0] wdata, input logic [LINE_WORDS-1:0] mask);
    @(posedge clk);
    #1;
    bus.i_re = ire;
    bus.i_addr = iaddr;
    bus.d_re = dre;
    bus.d_we = dwe;
    bus.d_addr = daddr;
    bus.d_wdata = wdata;
    bus.d_wmask = mask;
  endtask

  // Counts cycles with rdy low from the current cycle until completion.
  task automatic waitRdy(input logic isD, output int lows);
    lows = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (isD ? bus.d_rdy : bus.i_rdy) return;
      lows++;
    end
    checks++;
    errors++;
    $display("[TB] FAIL wait_rdy timeout ch=%0d: got no rdy expected rdy within 40 cycles", isD);
  endtask

  task automatic agentI(input int n);
    logic active = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (!active || doneI) begin
        if ($urandom_range(0, 3) != 0) begin
          active = 1'b1;
          bus.i_re = 1'b1;
          bus.i_addr = ADDR_W'(32'h100 + $urandom_range(0, 7));
        end else begin
          active = 1'b0;
          bus.i_re = 1'b0;
        end
      end
    end
  endtask

  task automatic agentD(input int n);
    logic active = 1'b0;
    int op;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (!active || doneD) begin
        op = int'($urandom_range(0, 3));
        active = (op != 0);
        bus.d_re = (op == 1) || (op == 3);
        bus.d_we = (op == 2) || (op == 3);
        bus.d_addr = ADDR_W'(32'h100 + $urandom_range(0, 7));
        bus.d_wdata = {$urandom, $urandom};
        bus.d_wmask = LINE_WORDS'($urandom_range(0, 15));
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lows, iAt, dAt, first, second;
    bus.i_re = 0; bus.i_addr = '0; bus.d_re = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.d_wmask = '0;
    bus2.i_re = 0; bus2.i_addr = '0; bus2.d_re = 0; bus2.d_we = 0;
    bus2.d_addr = '0; bus2.d_wdata = '0; bus2.d_wmask = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_i_rdy", LW'(bus.i_rdy), 64'd1);
    checkOutput("reset_d_rdy", LW'(bus.d_rdy), 64'd1);
    checkOutput("reset_i_rdata", bus.i_rdata, 64'd0);
    checkOutput("reset_d_rdata", bus.d_rdata, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full write then instruction read of the same line
    applyStimulus(0, '0, 0, 1, 14'h0010, 64'h4444_3333_2222_1111, 4'hF);
    waitRdy(1'b1, lows);
    checkOutput("wr10_latency", LW'(lows), 64'd4);
    applyStimulus(1, 14'h0010, 0, 0, '0, '0, '0);
    waitRdy(1'b0, lows);
    checkOutput("rd10_latency", LW'(lows), 64'd4);
    checkOutput("rd10_data", bus.i_rdata, 64'h4444_3333_2222_1111);

    // Masked write, then data read
    applyStimulus(0, '0, 0, 1, 14'h0010, 64'hDDDD_CCCC_BBBB_AAAA, 4'b0101);
    waitRdy(1'b1, lows);
    applyStimulus(0, '0, 1, 0, 14'h0010, '0, '0);
    waitRdy(1'b1, lows);
    checkOutput("masked_data", bus.d_rdata, 64'h4444_CCCC_2222_AAAA);

    // Simultaneous instruction and data reads
    applyStimulus(1, 14'h0010, 1, 0, 14'h0010, '0, '0);
    iAt = -1;
    dAt = -1;
    for (int k = 0; k < 40 && (iAt < 0 || dAt < 0); k++) begin
      @(negedge clk);
      if (iAt < 0 && bus.i_rdy) iAt = k;
      if (dAt < 0 && bus.d_rdy) dAt = k;
      @(posedge clk);
      #1;
      if (iAt >= 0) bus.i_re = 1'b0;
      if (dAt >= 0) bus.d_re = 1'b0;
    end
`ifdef UMEM_RR_ARB_EN
    checkOutput("tie_i_done", LW'(iAt), 64'd4);
    checkOutput("tie_d_done", LW'(dAt), 64'd9);
`else
    checkOutput("tie_d_done", LW'(dAt), 64'd4);
    checkOutput("tie_i_done", LW'(iAt), 64'd9);
`endif
    checkOutput("tie_i_data", bus.i_rdata, 64'h4444_CCCC_2222_AAAA);

    // Read and write together is a write; d_rdata keeps its old line
    applyStimulus(0, '0, 1, 1, 14'h0020, 64'h1234_5678_9ABC_DEF0, 4'hF);
    waitRdy(1'b1, lows);
    checkOutput("rw_keeps_d_rdata", bus.d_rdata, 64'h4444_CCCC_2222_AAAA);
    applyStimulus(1, 14'h0020, 0, 0, '0, '0, '0);
    waitRdy(1'b0, lows);
    checkOutput("rw_wrote_line", bus.i_rdata, 64'h1234_5678_9ABC_DEF0);

    // Reset during a write aborts it
    applyStimulus(0, '0, 0, 1, 14'h0030, 64'h0BAD_F00D_CAFE_0001, 4'hF);
    waitRdy(1'b1, lows);
    applyStimulus(0, '0, 0, 1, 14'h0030, 64'hFFFF_EEEE_DDDD_CCCC, 4'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.d_we = 1'b0;
    @(negedge clk);
    checkOutput("midrst_i_rdy", LW'(bus.i_rdy), 64'd1);
    checkOutput("midrst_d_rdy", LW'(bus.d_rdy), 64'd1);
    checkOutput("midrst_i_rdata", bus.i_rdata, 64'd0);
    checkOutput("midrst_d_rdata", bus.d_rdata, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Held read interrupted by reset restarts with the full latency
    applyStimulus(1, 14'h0030, 0, 0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("held_rst_i_rdy", LW'(bus.i_rdy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitRdy(1'b0, lows);
    checkOutput("restart_latency", LW'(lows), 64'd4);
    checkOutput("aborted_write_old", bus.i_rdata, 64'h0BAD_F00D_CAFE_0001);

    // Randomised traffic on a small set of initialised lines
    for (int a = 0; a < 8; a++) begin
      applyStimulus(0, '0, 0, 1, ADDR_W'(32'h100 + a), {$urandom, $urandom}, 4'hF);
      waitRdy(1'b1, lows);
    end
    applyStimulus(0, '0, 0, 0, '0, '0, '0);
    fork
      agentI(2000);
      agentD(2000);
    join
    applyStimulus(0, '0, 0, 0, '0, '0, '0);
    repeat (8) @(posedge clk);

    // LATENCY = 2 instance: write, then two back-to-back reads
    @(posedge clk);
    #1;
    bus2.d_we = 1'b1;
    bus2.d_addr = 14'h0005;
    bus2.d_wdata = 64'h5555_6666_7777_8888;
    bus2.d_wmask = 4'hF;
    first = -1;
    for (int k = 0; k < 20 && first < 0; k++) begin
      @(negedge clk);
      if (bus2.d_rdy) first = k;
    end
    checkOutput("lat2_write_done", LW'(first), 64'd2);
    @(posedge clk);
    #1;
    bus2.d_we = 1'b0;
    bus2.d_re = 1'b1;
    first = -1;
    second = -1;
    for (int k = 0; k < 20 && second < 0; k++) begin
      @(negedge clk);
      if (bus2.d_rdy) begin
        if (first < 0) first = k;
        else second = k;
      end
    end
    @(posedge clk);
    #1;
    bus2.d_re = 1'b0;
    checkOutput("lat2_first_read", LW'(first), 64'd2);
    checkOutput("lat2_second_read", LW'(second), 64'd5);
    checkOutput("lat2_read_data", bus2.d_rdata, 64'h5555_6666_7777_8888);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unified_mem_arb.md
# unified_mem_arb

Parametrised, two-channel successor to the single-port unified data memory. It serves an instruction channel (read-only) and a data channel (read/write with per-word write mask) from one shared line-organised array. Accesses are serialised through an arbiter and have a configurable fixed latency. It sits below the I-cache and D-cache miss handlers and replaces separate instruction and data backing memories.

## Interface
Parameters:
- WORD_W, 16: width of one addressable memory word.
- LINE_WORDS, 4: words per line. Line width is LW = WORD_W*LINE_WORDS.
- ADDR_W, 14: line-address width. Depth is 2**ADDR_W lines.
- LATENCY, 4: cycles from accept to completion. Legal range 2..16.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_re  in  1  instruction-channel read request (level).
- i_addr  in  ADDR_W  instruction line address.
- i_rdata  out  LW  instruction read line.
- i_rdy  out  1  instruction channel ready/complete.
- d_re  in  1  data-channel read request (level).
- d_we  in  1  data-channel write request (level).
- d_addr  in  ADDR_W  data line address.
- d_wdata  in  LW  data write line.
- d_wmask  in  LINE_WORDS  per-word write enable; bit k covers word k, at bits [k*WORD_W +: WORD_W].
- d_rdata  out  LW  data read line.
- d_rdy  out  1  data channel ready/complete.

## Operation
- Requester protocol:
  - Assert the request and hold address, data and mask stable until the channel's rdy is high while the request is asserted (the completion cycle).
  - A request still asserted in the cycle after completion starts a new access.
- `x_rdy` is combinational:
  - 1 when that channel has no request asserted.
  - 1 in that channel's completion cycle.
  - 0 otherwise.
- Data channel with d_we and d_re both high is treated as a write.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: with any request, grant one channel, capture its addr/wdata/mask/op and the grant ID, clear the counter, go to ACCESS. With no request, stay in IDLE.
  - ACCESS: count up. When count == LATENCY-2, perform the array operation at that edge and go to DONE.
  - DONE: assert rdy for the granted channel, go to IDLE unconditionally.
- Array operation:
  - Write: update only the words whose mask bit is set. Mask 0 is a legal no-op write that still completes.
  - Read: load the granted channel's rdata register with the full line.
- rdata holds its value until the next read completion on the same channel. Writes never alter d_rdata.
- Requests that are not granted wait with rdy = 0. There is no queue; the held request line is the queue.
- Array contents are not reset and are X until written.

## Timing
- Accept in IDLE at cycle T.
- ACCESS covers cycles T+1..T+LATENCY-1.
- DONE is cycle T+LATENCY; rdy = 1 and rdata is valid in that cycle.
- Earliest next accept is T+LATENCY+1.
- Sustained throughput is one access per LATENCY+1 cycles, shared by both channels.
- A write committed at the edge ending T+LATENCY-1 is visible to any read accepted at T+LATENCY+1 or later.
- Counter width is $clog2(LATENCY). It never wraps in use.
- Reset values:
  - state = IDLE, counter = 0, grant = data.
  - i_rdata = 0, d_rdata = 0.
  - rdy = 1 for each channel with no request asserted.
- Reset mid-operation aborts the access: a pending write is discarded and the array is unchanged. A request still held after reset is re-arbitrated from IDLE.

## Configuration
- UMEM_RR_ARB_EN defined:
  - Round-robin arbitration; the channel not granted last wins a tie.
  - The last-grant flop resets to data, so instruction wins the first tie.
- UMEM_RR_ARB_EN undefined:
  - Fixed priority, data over instruction.
  - The instruction channel can starve while the data channel requests continuously.

## Structure
- Package unified_mem_pkg:
  - umem_state_t enum (IDLE, ACCESS, DONE).
  - Channel IDs CH_I = 0, CH_D = 1.
  - Default parameter constants.
- Sub-module umem_arbiter: two requests in, one-hot grant out, plus a grant-advance input. It contains the round-robin/fixed logic selected by UMEM_RR_ARB_EN.

## Test plan
- Reset, then d_we with addr 0x0010, wdata 0x4444_3333_2222_1111, mask 4'hF. Then i_re to 0x0010. Required: i_rdy low for 4 cycles, high in cycle 5 with i_rdata = 0x4444_3333_2222_1111.
- Masked write, mask 4'b0101, wdata 0xDDDD_CCCC_BBBB_AAAA, to the same line; then d_re. Required: d_rdata = 0x4444_CCCC_2222_AAAA.
- i_re and d_re asserted in the same cycle:
  - RR build: instruction completes at T+4, data at T+9.
  - Fixed build: data first.
- d_re and d_we both high to addr 0x0020. Required: a write occurs, and d_rdata is unchanged at completion.
- rst_n pulsed low during ACCESS of a write to 0x0030. Required: all outputs at reset values; a later read shows the old contents; a held request restarts with a full latency.
- LATENCY = 2 build: back-to-back data reads complete at T+2 and T+5.
